id_stage_pipe: RTL

//  Parametrised instruction-decode stage for the MIPS pipeline: register-file read, control decode,
//  WB->ID bypass, load-use interlock and a registered ID/EX output bank with valid/ready handshake.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/id_regfile.sv | 53 +++++
 rtl/id_stage_pipe.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct encodings, ALU codes and ctrl bit positions for the MIPS ID stage
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_e;

  // ctrl vector layout: {regdst, alu_src_imm, mem_to_reg, branch, reg_write, mem_write}
  localparam int CTRL_W           = 6;
  localparam int CTRL_REGDST      = 5;
  localparam int CTRL_ALU_SRC_IMM = 4;
  localparam int CTRL_MEM_TO_REG  = 3;
  localparam int CTRL_BRANCH      = 2;
  localparam int CTRL_REG_WRITE   = 1;
  localparam int CTRL_MEM_WRITE   = 0;

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - 2-read/1-write register file with r0 hardwired to zero and optional WB bypass
//   clk, rst_n      : clock, async active-low reset (all entries cleared)
//   ra1/ra2 -> rd1/rd2 : combinational read ports
//   we, wa, wd      : write port, takes effect on the rising edge
module id_regfile #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_WB = 1,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Writes to r0 are discarded so it always reads back as zero.
  logic wr_en;
  assign wr_en = we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // The WB value being written this cycle is returned directly, so a
  // producer three stages ahead needs no extra stall.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
    if (BYPASS_WB != 0) begin
      if (wr_en && (wa == ra1)) rd1 = wd;
      if (wr_en && (wa == ra2)) rd2 = wd;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - MIPS decode stage: regfile read, control decode, load-use interlock, ID/EX register
//   IF side : if_valid, if_instr in; id_ready out (accept when if_valid & id_ready)
//   control : flush squashes the ID instruction and the ID/EX entry
//   WB side : wb_we, wb_dst, wb_data write the register file
//   EX side : ex_valid, ex_instr, ex_rs_data, ex_rt_data, ex_imm, ex_dst, ex_ctrl,
//             ex_mem_read, ex_alu_op out; ex_ready in (EX consumes the entry)
module id_stage_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_WB = 1,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  output logic              id_ready,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [31:0]       ex_instr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_dst,
  output logic [5:0]        ex_ctrl,
  output logic              ex_mem_read,
  output logic [3:0]        ex_alu_op
);

  // Instruction fields
  logic [5:0]      opcode, funct;
  logic [4:0]      rs_f, rt_f, rd_f;
  logic [RA_W-1:0] rs, rt, rd;

  assign opcode = if_instr[31:26];
  assign rs_f   = if_instr[25:21];
  assign rt_f   = if_instr[20:16];
  assign rd_f   = if_instr[15:11];
  assign funct  = if_instr[5:0];
  assign rs     = rs_f[RA_W-1:0];
  assign rt     = rt_f[RA_W-1:0];
  assign rd     = rd_f[RA_W-1:0];

  logic [DATA_W-1:0] rs_data, rt_data, imm_ext;
  assign imm_ext = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  id_regfile #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .BYPASS_WB (BYPASS_WB)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_data),
    .rd2   (rt_data),
    .we    (wb_we),
    .wa    (wb_dst),
    .wd    (wb_data)
  );

  // Control decode
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_mem_read;
  logic              dec_uses_rt;
  alu_op_e           dec_alu_op;
  logic [RA_W-1:0]   dec_dst;

  always_comb begin
    dec_ctrl     = '0;
    dec_mem_read = 1'b0;
    dec_uses_rt  = 1'b0;
    dec_alu_op   = ALU_NOP;
    case (opcode)
      OP_RTYPE: begin
        dec_uses_rt = 1'b1;
        case (funct)
          FN_ADD: dec_alu_op = ALU_ADD;
          FN_SUB: dec_alu_op = ALU_SUB;
          FN_AND: dec_alu_op = ALU_AND;
          FN_OR:  dec_alu_op = ALU_OR;
          FN_SLT: dec_alu_op = ALU_SLT;
          default: dec_alu_op = ALU_NOP;
        endcase
        // The all-zero word is the canonical nop: a harmless write to r0.
        if (dec_alu_op != ALU_NOP || if_instr == 32'h0) begin
          dec_ctrl[CTRL_REGDST]    = 1'b1;
          dec_ctrl[CTRL_REG_WRITE] = 1'b1;
        end
      end
      OP_ADDI: begin
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        dec_ctrl[CTRL_REG_WRITE]   = 1'b1;
        dec_alu_op                 = ALU_ADD;
      end
      OP_LW: begin
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        dec_ctrl[CTRL_MEM_TO_REG]  = 1'b1;
        dec_ctrl[CTRL_REG_WRITE]   = 1'b1;
        dec_mem_read               = 1'b1;
        dec_alu_op                 = ALU_ADD;
      end
      OP_SW: begin
        dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        dec_ctrl[CTRL_MEM_WRITE]   = 1'b1;
        dec_uses_rt                = 1'b1;
        dec_alu_op                 = ALU_ADD;
      end
      OP_BEQ: begin
        dec_ctrl[CTRL_BRANCH] = 1'b1;
        dec_uses_rt           = 1'b1;
        dec_alu_op            = ALU_SUB;
      end
      default: ;
    endcase
    dec_dst = dec_ctrl[CTRL_REGDST] ? rd : rt;
  end

  // ID/EX register
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [RA_W-1:0]   dst_q, dst_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              mem_read_q, mem_read_d;
  logic [3:0]        alu_op_q, alu_op_d;

  // Load-use interlock: the load in ID/EX has not fetched its data yet.
  logic hz;
  assign hz = valid_q && mem_read_q && (dst_q != '0) &&
              ((dst_q == rs) || ((dst_q == rt) && dec_uses_rt));

  logic ex_free, load;
  assign ex_free  = !valid_q || ex_ready;
  assign id_ready = !hz && ex_free && !flush;
  assign load     = if_valid && id_ready;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    dst_d      = dst_q;
    ctrl_d     = ctrl_q;
    mem_read_d = mem_read_q;
    alu_op_d   = alu_op_q;
    if (flush) begin
      valid_d    = 1'b0;
      ctrl_d     = '0;
      mem_read_d = 1'b0;
      alu_op_d   = ALU_NOP;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = if_instr;
      rs_data_d  = rs_data;
      rt_data_d  = rt_data;
      imm_d      = imm_ext;
      dst_d      = dec_dst;
      ctrl_d     = dec_ctrl;
      mem_read_d = dec_mem_read;
      alu_op_d   = dec_alu_op;
    end else if (ex_free) begin
      // Entry consumed with nothing to replace it (stall or empty IF/ID): bubble.
      valid_d    = 1'b0;
      ctrl_d     = '0;
      mem_read_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      dst_q      <= '0;
      ctrl_q     <= '0;
      mem_read_q <= 1'b0;
      alu_op_q   <= ALU_NOP;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      dst_q      <= dst_d;
      ctrl_q     <= ctrl_d;
      mem_read_q <= mem_read_d;
      alu_op_q   <= alu_op_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_instr    = instr_q;
  assign ex_rs_data  = rs_data_q;
  assign ex_rt_data  = rt_data_q;
  assign ex_imm      = imm_q;
  assign ex_dst      = dst_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_mem_read = mem_read_q;
  assign ex_alu_op   = alu_op_q;

endmodule
